booth_mult: RTL and testbench

Parametrised sequential multiplier, successor to the team's fixed 16-bit signed `mult`. It computes a WIDTH×WIDTH product with a radix-2 Booth datapath in WIDTH+1 iteration cycles and adds a per-operation signed/unsigned mode. It adds an explicit busy indication and a `ready` that is held until the next start. It sits behind any controller that drives a start/ready handshake and replaces `mult` where other widths or unsigned operands are needed.

---
 rtl/mult_pkg.sv | 35 +++
 rtl/booth_step.sv | 33 +++
 rtl/booth_mult.sv | 122 ++++++++++++
 tb/tb_booth_mult.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the Booth multiplier.
//   mult_state_t        : controller state encoding (IDLE, CALC, DONE)
//   MULT_DEFAULT_WIDTH  : default operand width
//   MULT_MAX_WIDTH      : widest operand mult_ext can extend
//   mult_ext()          : sign/zero extension of an operand by one bit
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

  localparam int unsigned MULT_DEFAULT_WIDTH = 16;
  localparam int unsigned MULT_MAX_WIDTH     = 64;
  localparam int unsigned MULT_IDX_W         = $clog2(MULT_MAX_WIDTH);

  // Extends a width-bit operand (zero-padded up to MULT_MAX_WIDTH by the caller)
  // to width+1 bits. Bits above bit 'width' are filled too, so the caller may
  // slice any extension width it needs.
  function automatic logic [MULT_MAX_WIDTH:0] mult_ext(
    input logic [MULT_MAX_WIDTH-1:0] value,
    input logic                      is_signed,
    input int unsigned               width
  );
    logic [MULT_MAX_WIDTH:0] upper;
    logic [MULT_IDX_W-1:0]   msb;
    logic                    sign;
    msb   = MULT_IDX_W'(width - 1);
    sign  = is_signed & value[msb];
    upper = {(MULT_MAX_WIDTH + 1){1'b1}} << width;
    return {1'b0, value} | (sign ? upper : '0);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
//   acc, q, q_1 : current accumulator, multiplier register and guard bit
//   m           : extended multiplicand
//   acc_next, q_next, q_1_next : state after add/sub and arithmetic right shift
module booth_step #(
  parameter int unsigned W1 = 17
) (
  input  logic [W1-1:0] acc,
  input  logic [W1-1:0] q,
  input  logic          q_1,
  input  logic [W1-1:0] m,
  output logic [W1-1:0] acc_next,
  output logic [W1-1:0] q_next,
  output logic          q_1_next
);

  logic [W1-1:0] sum;

  always_comb begin
    sum = acc;
    unique case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // Arithmetic right shift of {sum, q, q_1} by one.
  assign acc_next = {sum[W1-1], sum[W1-1:1]};
  assign q_next   = {sum[0], q[W1-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
//   clk, rst  : rising-edge clock, asynchronous active-low reset
//   start     : request, accepted in IDLE or DONE
//   is_signed : operand mode, captured with a and b
//   a, b      : multiplicand, multiplier
//   busy      : high while iterating
//   ready     : result valid, held until the next accepted start
//   c         : product, holds the last result
module booth_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] c
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned CW = $clog2(W1 + 1);

  mult_state_t state_q, state_d;

  logic [W1-1:0]      m_q, acc_q, q_q;
  logic               q1_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] c_q;
  logic               ready_q;

  logic               load, last;
  logic [W1-1:0]      acc_n, q_n;
  logic               q1_n;
  logic [2*W1-1:0]    full_n;

  logic [MULT_MAX_WIDTH:0] a_ext_full, b_ext_full;
  logic                    unused_bits;

  assign a_ext_full  = mult_ext(MULT_MAX_WIDTH'(a), is_signed, WIDTH);
  assign b_ext_full  = mult_ext(MULT_MAX_WIDTH'(b), is_signed, WIDTH);
  assign full_n      = {acc_n, q_n};
  // The top two product bits are pure sign extension and never leave the block.
  assign unused_bits = ^{full_n[2*W1-1:2*WIDTH],
                         a_ext_full[MULT_MAX_WIDTH:W1], b_ext_full[MULT_MAX_WIDTH:W1]};

  booth_step #(
    .W1 (W1)
  ) u_step (
    .acc      (acc_q),
    .q        (q_q),
    .q_1      (q1_q),
    .m        (m_q),
    .acc_next (acc_n),
    .q_next   (q_n),
    .q_1_next (q1_n)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // start is deliberately ignored here
        if (cnt_q == CW'(W1 - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      ready_q <= 1'b0;
    end else if (load) begin
      m_q     <= a_ext_full[W1-1:0];
      q_q     <= b_ext_full[W1-1:0];
      acc_q   <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == CALC) begin
      acc_q <= acc_n;
      q_q   <= q_n;
      q1_q  <= q1_n;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        c_q     <= full_n[2*WIDTH-1:0];
        ready_q <= 1'b1;
      end
    end
  end

  assign busy  = (state_q == CALC);
  assign ready = ready_q;
  assign c     = c_q;

endmodule

// File: tb/tb_booth_mult.sv
module tb_booth_mult;

  logic clk, rst;

  logic        st16, sg16, busy16, rdy16;
  logic [15:0] a16, b16;
  logic [31:0] c16;

  logic        st8, sg8, busy8, rdy8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;

  logic        st4, sg4, busy4, rdy4;
  logic [3:0]  a4, b4;
  logic [7:0]  c4;

  int total = 0;
  int bad   = 0;
  logic [31:0] last16;

  booth_mult #(.WIDTH(16)) u_d16 (
    .clk(clk), .rst(rst), .start(st16), .is_signed(sg16), .a(a16), .b(b16),
    .busy(busy16), .ready(rdy16), .c(c16)
  );
  booth_mult #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst(rst), .start(st8), .is_signed(sg8), .a(a8), .b(b8),
    .busy(busy8), .ready(rdy8), .c(c8)
  );
  booth_mult #(.WIDTH(4)) u_d4 (
    .clk(clk), .rst(rst), .start(st4), .is_signed(sg4), .a(a4), .b(b4),
    .busy(busy4), .ready(rdy4), .c(c4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One 16-bit operation: latency, mid-operation hold of c, and final product.
  task automatic run16(input string nm, input logic sg, input logic [15:0] aa,
                       input logic [15:0] bb, input logic [31:0] exp);
    int n;
    @(negedge clk);
    sg16 = sg; a16 = aa; b16 = bb; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    chk({nm, " busy@start"}, 64'(busy16), 64'(1));
    chk({nm, " ready@start"}, 64'(rdy16), 64'(0));
    n = 0;
    while (!rdy16 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 8) chk({nm, " c hold"}, 64'(c16), 64'(last16));
    end
    chk({nm, " latency"}, 64'(n), 64'(17));
    chk({nm, " c"}, 64'(c16), 64'(exp));
    chk({nm, " busy@done"}, 64'(busy16), 64'(0));
    last16 = exp;
  endtask

  typedef struct {
    string       nm;
    logic        sg;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] c;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n, rises, highs;
    logic prev;

    vecs[0] = '{"s 49x23",      1'b1, 16'd49,    16'd23,    32'd1127};
    vecs[1] = '{"s -49x23",     1'b1, 16'hFFCF,  16'd23,    32'hFFFF_FB99};
    vecs[2] = '{"s -49x-23",    1'b1, 16'hFFCF,  16'hFFE9,  32'd1127};
    vecs[3] = '{"s 49x-23",     1'b1, 16'd49,    16'hFFE9,  32'hFFFF_FB99};
    vecs[4] = '{"s min x min",  1'b1, 16'h8000,  16'h8000,  32'h4000_0000};
    vecs[5] = '{"s min x max",  1'b1, 16'h8000,  16'h7FFF,  32'hC000_8000};
    vecs[6] = '{"u ffff^2",     1'b0, 16'hFFFF,  16'hFFFF,  32'hFFFE_0001};
    vecs[7] = '{"s -1x-1",      1'b1, 16'hFFFF,  16'hFFFF,  32'd1};
    vecs[8] = '{"u 8000x2",     1'b0, 16'h8000,  16'd2,     32'h0001_0000};
    vecs[9] = '{"s 8000x2",     1'b1, 16'h8000,  16'd2,     32'hFFFF_0000};

    rst = 1'b0;
    st16 = 0; sg16 = 0; a16 = 0; b16 = 0;
    st8 = 0;  sg8 = 0;  a8 = 0;  b8 = 0;
    st4 = 0;  sg4 = 0;  a4 = 0;  b4 = 0;
    last16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy16), 64'(0));
    chk("reset ready", 64'(rdy16), 64'(0));
    chk("reset c", 64'(c16), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run16(vecs[i].nm, vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].c);

    // start re-pulsed mid-CALC with new operands: original result, on time.
    @(negedge clk);
    sg16 = 1'b1; a16 = 16'd49; b16 = 16'd23; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    n = 0;
    while (!rdy16 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) begin
        st16 = 1'b1; a16 = 16'd7; b16 = 16'd9; sg16 = 1'b0;
      end
      if (n == 6) st16 = 1'b0;
    end
    chk("midstart latency", 64'(n), 64'(17));
    chk("midstart c", 64'(c16), 64'(1127));
    last16 = 32'd1127;

    // start held high for 40 edges: one ready pulse per operation.
    @(negedge clk);
    sg16 = 1'b1; a16 = 16'hFFCF; b16 = 16'd23; st16 = 1'b1;
    rises = 0; highs = 0; prev = rdy16;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (rdy16 && !prev) rises++;
      if (rdy16) highs++;
      if (rdy16 && busy16) chk("held ready&busy", 64'(1), 64'(0));
      prev = rdy16;
    end
    st16 = 1'b0;
    chk("held rises", 64'(rises), 64'(2));
    chk("held high cycles", 64'(highs), 64'(2));
    n = 0;
    while (!rdy16 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held final ready", 64'(rdy16), 64'(1));
    chk("held final c", 64'(c16), 64'(32'hFFFF_FB99));

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    sg16 = 1'b1; a16 = 16'd49; b16 = 16'd23; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst busy", 64'(busy16), 64'(0));
    chk("rst ready", 64'(rdy16), 64'(0));
    chk("rst c", 64'(c16), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    last16 = '0;
    run16("after rst", 1'b1, 16'hFFCF, 16'hFFE9, 32'd1127);

    // WIDTH=8 unsigned 200x3.
    @(negedge clk);
    sg8 = 1'b0; a8 = 8'd200; b8 = 8'd3; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    n = 0;
    while (!rdy8 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w8 latency", 64'(n), 64'(9));
    chk("w8 c", 64'(c8), 64'(16'd600));

    // WIDTH=4 signed -8x7.
    @(negedge clk);
    sg4 = 1'b1; a4 = 4'h8; b4 = 4'h7; st4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    n = 0;
    while (!rdy4 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w4 latency", 64'(n), 64'(5));
    chk("w4 c", 64'(c4), 64'(8'hC8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
